// File: rtl/ftdi_frame_rx.sv
`default_nettype none
// ============================================================================
// Module      : ftdi_frame_rx
// Description : Delimits the FTDI reader byte stream into command frames
//               (SYNC, OPCODE, LEN, payload[, CHK]). Payload is packed into
//               little-endian words tagged with opcode and last-word flag.
//               Checksum and timeout faults are flagged with one-cycle pulses.
//               Optional feature macro: FTDI_FRAME_CHECKSUM_EN (adds the CHK
//               byte and XOR checksum comparison).
// Revision    : 1.0 - initial release
// ============================================================================
module ftdi_frame_rx #(
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [8*WORD_BYTES-1:0] out_word,
    output logic [7:0]              out_opcode,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    frame_done,
    output logic                    frame_err,
    output logic [1:0]              err_code,
    output logic [7:0]              drop_cnt
);

    localparam logic [7:0]       C_SYNC     = 8'hA5;
    localparam int               IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] C_TMO_ONE  = TMO_W'(1);

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_OPC  = 3'd1,
        S_LEN  = 3'd2,
`ifdef FTDI_FRAME_CHECKSUM_EN
        S_PAY  = 3'd3,
        S_CHK  = 3'd4
`else
        S_PAY  = 3'd3
`endif
    } state_t;

    state_t                  r_state;
    logic [7:0]              r_opcode;
    logic [7:0]              r_words_left;
    logic [IDX_W-1:0]        r_byte_idx;
    logic [8*WORD_BYTES-1:0] r_assem;
    logic [TMO_W-1:0]        r_tmo_cnt;
`ifdef FTDI_FRAME_CHECKSUM_EN
    logic [7:0]              r_chk;
`endif

    logic                    w_completes;
    logic                    w_accept;
    logic                    w_expire;
    logic [8*WORD_BYTES-1:0] w_word;

    // The byte closing a word can only be taken if the output register is free
    // or draining this cycle; every other byte is always accepted.
    assign w_completes = (r_state == S_PAY) && (r_byte_idx == C_LAST_IDX);
    assign in_ready    = !(w_completes && out_valid && !out_ready);
    assign w_accept    = in_valid && in_ready;
    // Idle mid-frame cycle that would bring the counter to TIMEOUT_CYCLES.
    assign w_expire    = (r_state != S_SYNC) && !in_valid && (r_tmo_cnt == C_TMO_LAST);

    // Word as it will look once the incoming byte fills the top lane.
    always_comb begin
        w_word = r_assem;
        w_word[8*(WORD_BYTES-1) +: 8] = in_data;
    end

    // Frame parser, word assembly, output register, timeout and error reporting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SYNC;
            r_opcode     <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_assem      <= '0;
            r_tmo_cnt    <= '0;
`ifdef FTDI_FRAME_CHECKSUM_EN
            r_chk        <= '0;
`endif
            out_word     <= '0;
            out_opcode   <= '0;
            out_last     <= 1'b0;
            out_valid    <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            err_code     <= 2'b00;
            drop_cnt     <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_accept) begin
                r_tmo_cnt <= '0;
            end else if ((r_state != S_SYNC) && !in_valid) begin
                r_tmo_cnt <= r_tmo_cnt + C_TMO_ONE;
            end

            if (w_expire) begin
                // Partial word is abandoned; a word already in out_word stays.
                frame_err  <= 1'b1;
                err_code   <= 2'b10;
                r_state    <= S_SYNC;
                r_tmo_cnt  <= '0;
                r_byte_idx <= '0;
            end else begin
                case (r_state)
                    S_SYNC: begin
                        r_tmo_cnt <= '0;
`ifdef FTDI_FRAME_CHECKSUM_EN
                        r_chk     <= '0;
`endif
                        if (w_accept) begin
                            if (in_data == C_SYNC) begin
                                r_state <= S_OPC;
                            end else if (drop_cnt != 8'hFF) begin
                                drop_cnt <= drop_cnt + 8'd1;
                            end
                        end
                    end
                    S_OPC: begin
                        if (w_accept) begin
                            r_opcode <= in_data;
`ifdef FTDI_FRAME_CHECKSUM_EN
                            r_chk    <= r_chk ^ in_data;
`endif
                            r_state  <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (w_accept) begin
                            r_words_left <= in_data;
                            r_byte_idx   <= '0;
`ifdef FTDI_FRAME_CHECKSUM_EN
                            r_chk        <= r_chk ^ in_data;
`endif
                            if (in_data == 8'd0) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                                r_state    <= S_CHK;
`else
                                r_state    <= S_SYNC;
                                frame_done <= 1'b1;
`endif
                            end else begin
                                r_state <= S_PAY;
                            end
                        end
                    end
                    S_PAY: begin
                        if (w_accept) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                            r_chk <= r_chk ^ in_data;
`endif
                            if (w_completes) begin
                                out_word     <= w_word;
                                out_opcode   <= r_opcode;
                                out_last     <= (r_words_left == 8'd1);
                                out_valid    <= 1'b1;
                                r_byte_idx   <= '0;
                                r_words_left <= r_words_left - 8'd1;
                                if (r_words_left == 8'd1) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                                    r_state    <= S_CHK;
`else
                                    r_state    <= S_SYNC;
                                    frame_done <= 1'b1;
`endif
                                end
                            end else begin
                                r_assem[{r_byte_idx, 3'b000} +: 8] <= in_data;
                                r_byte_idx <= r_byte_idx + C_IDX_ONE;
                            end
                        end
                    end
`ifdef FTDI_FRAME_CHECKSUM_EN
                    S_CHK: begin
                        if (w_accept) begin
                            if (in_data == r_chk) begin
                                frame_done <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                                err_code  <= 2'b01;
                            end
                            r_state <= S_SYNC;
                        end
                    end
`endif
                    default: r_state <= S_SYNC;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
